// File: rtl/sparse_mac_row_ctrl.sv
// rtl/sparse_mac_row_ctrl.sv - sequencing controller for one sparse MAC row
module sparse_mac_row_ctrl #(
  parameter int STEP_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int DRAIN_CYC = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic [STEP_W-1:0] num_steps_i,
  input  logic [ADDR_W-1:0] act_base_i,
  input  logic [ADDR_W-1:0] wgt_base_i,
  input  logic              act_valid_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              mac_execute_o,
  output logic              mac_load_o,
  output logic              mac_a_select_o,
  output logic [ADDR_W-1:0] act_addr_o,
  output logic [ADDR_W-1:0] wgt_addr_o,
  output logic [STEP_W-1:0] step_cnt_o
);

  localparam int CNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PRELOAD = 3'd1,
    S_RUN     = 3'd2,
    S_DRAIN   = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [STEP_W-1:0] num_steps_q, num_steps_d;
  logic [CNT_W-1:0]  drain_cnt_q, drain_cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              exec_q, exec_d;
  logic              load_q, load_d;
  logic              asel_q, asel_d;
  logic [ADDR_W-1:0] act_addr_q, act_addr_d;
  logic [ADDR_W-1:0] wgt_addr_q, wgt_addr_d;
  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;

  // A step is issued in the RUN cycle whose registered outputs show execute.
  logic issue;
  logic last_step;
  assign issue     = (state_q == S_RUN) && exec_q;
  assign last_step = issue && ((step_cnt_q + STEP_W'(1)) == num_steps_q);

  // State and registered outputs; synchronous reset aborts any job with no done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      num_steps_q <= '0;
      drain_cnt_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      exec_q      <= 1'b0;
      load_q      <= 1'b0;
      asel_q      <= 1'b0;
      act_addr_q  <= '0;
      wgt_addr_q  <= '0;
      step_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      num_steps_q <= num_steps_d;
      drain_cnt_q <= drain_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      exec_q      <= exec_d;
      load_q      <= load_d;
      asel_q      <= asel_d;
      act_addr_q  <= act_addr_d;
      wgt_addr_q  <= wgt_addr_d;
      step_cnt_q  <= step_cnt_d;
    end
  end

  // Next-state: start is only honoured in IDLE, so busy/DONE-cycle starts are dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start_i) state_d = S_PRELOAD;
      S_PRELOAD: state_d = (num_steps_q != '0) ? S_RUN : S_DRAIN;
      S_RUN:     if (last_step) state_d = S_DRAIN;
      S_DRAIN:   if (drain_cnt_q == CNT_W'(DRAIN_CYC - 1)) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Next values of the registered strobes, addresses and counters.
  always_comb begin
    num_steps_d = num_steps_q;
    act_addr_d  = act_addr_q;
    wgt_addr_d  = wgt_addr_q;
    step_cnt_d  = step_cnt_q;
    asel_d      = asel_q;
    drain_cnt_d = (state_q == S_DRAIN) ? drain_cnt_q + CNT_W'(1) : '0;
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    load_d      = (state_d == S_PRELOAD);
    // act_valid seen now becomes next cycle's execute, so stalls show one cycle late.
    exec_d      = (state_d == S_PRELOAD) || ((state_d == S_RUN) && act_valid_i);

    if ((state_q == S_IDLE) && start_i) begin
      num_steps_d = num_steps_i;
      act_addr_d  = act_base_i;
      wgt_addr_d  = wgt_base_i;
      step_cnt_d  = '0;
      asel_d      = 1'b0;
    end else if (issue) begin
      step_cnt_d = step_cnt_q + STEP_W'(1);
      wgt_addr_d = wgt_addr_q + ADDR_W'(1);
      asel_d     = ~asel_q;
      // The pair address moves on only after its second activation was used.
      if (asel_q) act_addr_d = act_addr_q + ADDR_W'(1);
    end
  end

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign mac_execute_o  = exec_q;
  assign mac_load_o     = load_q;
  assign mac_a_select_o = asel_q;
  assign act_addr_o     = act_addr_q;
  assign wgt_addr_o     = wgt_addr_q;
  assign step_cnt_o     = step_cnt_q;

endmodule

// File: tb/tb_sparse_mac_row_ctrl.sv
// tb/tb_sparse_mac_row_ctrl.sv - self-checking bench for sparse_mac_row_ctrl
module tb_sparse_mac_row_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_i;
  logic [7:0] num_steps_i;
  logic [7:0] act_base_i;
  logic [7:0] wgt_base_i;
  logic       act_valid_i;
  logic       busy_o, done_o, mac_execute_o, mac_load_o, mac_a_select_o;
  logic [7:0] act_addr_o, wgt_addr_o, step_cnt_o;

  sparse_mac_row_ctrl #(.STEP_W(8), .ADDR_W(8), .DRAIN_CYC(3)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .num_steps_i(num_steps_i),
    .act_base_i(act_base_i), .wgt_base_i(wgt_base_i), .act_valid_i(act_valid_i),
    .busy_o(busy_o), .done_o(done_o), .mac_execute_o(mac_execute_o),
    .mac_load_o(mac_load_o), .mac_a_select_o(mac_a_select_o),
    .act_addr_o(act_addr_o), .wgt_addr_o(wgt_addr_o), .step_cnt_o(step_cnt_o)
  );

  always #5 clk = ~clk;

  // mode 0: control strobes only; 1: plus step count; 2: everything
  typedef struct {
    int         mode;
    logic       busy, done, exec, load, asel, stall;
    logic [7:0] act, wgt, cnt;
  } exp_t;

  exp_t q[$];
  exp_t cur_exp;
  exp_t zero_all;
  exp_t zero_ctl;
  bit   exp_on = 0;
  int   cur_idx = 0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   done_cyc = -1;
  int   obs_exec = 0;
  int   job_start_cyc = 0;
  int   exec_base = 0;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s idx=%0d got=%0h expected=%0h", nm, cur_idx, a, e);
    end
  endtask

  // Expected cycle trace of a job, built from the job description:
  // preload, steps (with optional stall cycles before step sp), 3 drain, done, idle.
  task automatic build(input int n, input logic [7:0] ab, input logic [7:0] wb,
                       input int sp, input int sl);
    exp_t e;
    q.delete();
    e = '{mode: 2, busy: 1, done: 0, exec: 1, load: 1, asel: 0, stall: 0,
          act: ab, wgt: wb, cnt: 8'd0};
    q.push_back(e);
    for (int k = 0; k < n; k++) begin
      e.mode = 2; e.busy = 1; e.done = 0; e.load = 0;
      e.asel = k[0];
      e.act  = 8'(ab + k / 2);
      e.wgt  = 8'(wb + k);
      e.cnt  = 8'(k);
      if (k == sp) begin
        for (int s = 0; s < sl; s++) begin
          e.exec = 0; e.stall = 1;
          q.push_back(e);
        end
      end
      e.exec = 1; e.stall = 0;
      q.push_back(e);
    end
    e = '{mode: 1, busy: 1, done: 0, exec: 0, load: 0, asel: 0, stall: 0,
          act: 8'd0, wgt: 8'd0, cnt: 8'(n)};
    for (int d = 0; d < 3; d++) q.push_back(e);
    e.done = 1;
    q.push_back(e);
    q.push_back(zero_ctl);
  endtask

  task automatic run_job(input int n, input logic [7:0] ab, input logic [7:0] wb,
                         input int sp, input int sl, input bit noise, input int abort);
    build(n, ab, wb, sp, sl);
    @(negedge clk);
    start_i = 1; num_steps_i = 8'(n); act_base_i = ab; wgt_base_i = wb; act_valid_i = 1;
    job_start_cyc = cyc;
    exec_base = obs_exec;
    cur_idx = 0; cur_exp = q[0]; exp_on = 1;
    for (int j = 1; j < q.size(); j++) begin
      @(negedge clk);
      if (j == abort) begin
        reset = 1; start_i = 0; cur_idx = j; cur_exp = zero_all;
        @(negedge clk);
        reset = 0; cur_exp = zero_ctl;
        @(negedge clk);
        exp_on = 0;
        return;
      end
      start_i = noise;
      if (noise) begin
        num_steps_i = 8'd7; act_base_i = 8'hAA; wgt_base_i = 8'h55;
      end
      act_valid_i = q[j].stall ? 1'b0 : 1'b1;
      cur_idx = j; cur_exp = q[j];
    end
    @(negedge clk);
    start_i = 0; exp_on = 0;
  endtask

  // Single compare process: checks DUT outputs against the trace each cycle.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (done_o) done_cyc = cyc;
    if (mac_execute_o) obs_exec++;
    if (exp_on) begin
      chk("busy", busy_o, cur_exp.busy);
      chk("done", done_o, cur_exp.done);
      chk("mac_execute", mac_execute_o, cur_exp.exec);
      chk("mac_load", mac_load_o, cur_exp.load);
      if (cur_exp.mode >= 1) chk("step_cnt", step_cnt_o, cur_exp.cnt);
      if (cur_exp.mode == 2) begin
        chk("a_select", mac_a_select_o, cur_exp.asel);
        chk("act_addr", act_addr_o, cur_exp.act);
        chk("wgt_addr", wgt_addr_o, cur_exp.wgt);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    zero_all = '{mode: 2, busy: 0, done: 0, exec: 0, load: 0, asel: 0, stall: 0,
                 act: 8'd0, wgt: 8'd0, cnt: 8'd0};
    zero_ctl = zero_all;
    zero_ctl.mode = 0;
    reset = 1; start_i = 0; num_steps_i = 0; act_base_i = 0; wgt_base_i = 0; act_valid_i = 0;
    cur_exp = zero_all; exp_on = 1;
    repeat (3) @(negedge clk);
    reset = 0; cur_exp = zero_ctl;
    @(negedge clk);
    exp_on = 0;

    // basic 4-step job
    run_job(4, 8'h10, 8'h20, -1, 0, 0, -1);
    chk("model_len_4", q.size(), 10);
    chk("model_act_step2", q[3].act, 8'h11);
    chk("lat_4", done_cyc - job_start_cyc, 9);
    chk("exec_cnt_4", obs_exec - exec_base, 5);

    // zero-step job still preloads and drains
    run_job(0, 8'h05, 8'h06, -1, 0, 0, -1);
    chk("lat_0", done_cyc - job_start_cyc, 5);
    chk("exec_cnt_0", obs_exec - exec_base, 1);

    // odd job with two stall cycles before the second step
    run_job(3, 8'h30, 8'h40, 1, 2, 0, -1);
    chk("model_stall_cnt", q[3].cnt, 8'd1);
    chk("lat_3_stall", done_cyc - job_start_cyc, 10);
    chk("exec_cnt_3", obs_exec - exec_base, 4);

    // start hammered during the job and in the DONE cycle, then a clean job
    run_job(5, 8'h50, 8'h60, -1, 0, 1, -1);
    chk("lat_5_noise", done_cyc - job_start_cyc, 10);
    run_job(2, 8'h70, 8'h80, -1, 0, 0, -1);
    chk("lat_2", done_cyc - job_start_cyc, 7);

    // reset while step 2 of 6 is showing, then a full 6-step job
    done_cyc = -1;
    run_job(6, 8'h11, 8'h22, -1, 0, 0, 4);
    chk("no_done_on_abort", done_cyc, 32'hFFFFFFFF);
    run_job(6, 8'h11, 8'h22, -1, 0, 0, -1);
    chk("lat_6", done_cyc - job_start_cyc, 11);

    // address wrap
    run_job(4, 8'hFF, 8'hFE, -1, 0, 0, -1);
    chk("model_wrap_act", q[3].act, 8'h00);
    chk("model_wrap_wgt", q[4].wgt, 8'h01);

    // maximum step count
    run_job(255, 8'h00, 8'h00, -1, 0, 0, -1);
    chk("lat_255", done_cyc - job_start_cyc, 260);
    chk("exec_cnt_255", obs_exec - exec_base, 256);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
